// File: rtl/la_zip_respmerge.sv
// -----------------------------------------------------------------------------
// la_zip_respmerge
//   Return-path merge for the bus interconnect. Every request accepted
//   downstream has its one-hot slave decode recorded in an in-order FIFO. The
//   oldest entry (head) selects which slave response channel is forwarded to
//   the single master response port. A head that decodes to "no slave"
//   (decode bit NS) is answered locally with a bus error.
//
// Ports
//   i_clk          clock
//   i_resetn       synchronous active-low reset
//   i_flush        drop all outstanding requests
//   i_req_valid    request accepted downstream this cycle
//   i_req_decode   one-hot decode of that request (bit NS = no slave)
//   o_req_stall    FIFO full, upstream must hold the request
//   i_rsp_valid    per-slave response strobe
//   i_rsp_err      per-slave error flag (qualified by i_rsp_valid)
//   i_rsp_data     per-slave read data, slave k at [k*DW +: DW]
//   o_rsp_valid    merged response strobe
//   o_rsp_err      merged error
//   o_rsp_data     merged data
//   o_outstanding  number of FIFO entries
//   o_fault        sticky: unexpected response or illegal decode seen
// -----------------------------------------------------------------------------
module la_zip_respmerge #(
  parameter int NS           = 8,
  parameter int DW           = 32,
  parameter int LGDEPTH      = 3,
  parameter bit OPT_LOWPOWER = 1'b0
) (
  input  logic               i_clk,
  input  logic               i_resetn,
  input  logic               i_flush,
  input  logic               i_req_valid,
  input  logic [NS:0]        i_req_decode,
  output logic               o_req_stall,
  input  logic [NS-1:0]      i_rsp_valid,
  input  logic [NS-1:0]      i_rsp_err,
  input  logic [NS*DW-1:0]   i_rsp_data,
  output logic               o_rsp_valid,
  output logic               o_rsp_err,
  output logic [DW-1:0]      o_rsp_data,
  output logic [LGDEPTH:0]   o_outstanding,
  output logic               o_fault
);

  localparam int             DEPTH     = 1 << LGDEPTH;
  localparam logic [LGDEPTH:0] DEPTH_CNT = (LGDEPTH+1)'(DEPTH);

  // Decode storage; written only on push, read asynchronously at the head.
  logic [NS:0]        fifo_mem [DEPTH];

  logic [LGDEPTH-1:0] wr_ptr_reg, wr_ptr_next;
  logic [LGDEPTH-1:0] rd_ptr_reg, rd_ptr_next;
  logic [LGDEPTH:0]   count_reg,  count_next;
  logic               rsp_valid_reg, rsp_valid_next;
  logic               rsp_err_reg,   rsp_err_next;
  logic [DW-1:0]      rsp_data_reg,  rsp_data_next;
  logic               fault_reg,     fault_next;

  logic               head_valid;
  logic [NS:0]        head_dec;
  logic [NS-1:0]      head_slave_sel;
  logic               decode_ok;
  logic               push;
  logic               pop;
  logic               slave_hit;
  logic               nsl_pop;
  logic               stray_rsp;
  logic [DW-1:0]      merged_data;
  logic               merged_err;

  logic [DW-1:0]      slave_data_masked [NS];
  logic [NS-1:0]      slave_err_masked;

  assign head_valid     = (count_reg != '0);
  assign head_dec       = fifo_mem[rd_ptr_reg];
  // Slave selection is forced to zero when the FIFO is empty so that stale
  // memory contents can never select a channel.
  assign head_slave_sel = head_valid ? head_dec[NS-1:0] : '0;

  assign o_req_stall = (count_reg == DEPTH_CNT);
  assign decode_ok   = $onehot(i_req_decode);
  assign push        = !i_flush && i_req_valid && !o_req_stall && decode_ok;

  assign slave_hit = |(i_rsp_valid & head_slave_sel);
  // A no-slave head retires in its first head cycle without any strobe.
  assign nsl_pop   = head_valid && head_dec[NS];
  assign pop       = !i_flush && (slave_hit || nsl_pop);

  // Any strobe not belonging to the head slave (including all strobes while
  // empty) is dropped and recorded as a fault.
  assign stray_rsp = |(i_rsp_valid & ~head_slave_sel);

  // AND-OR response mux driven by the one-hot head selection.
  for (genvar gi = 0; gi < NS; gi++) begin : g_slave_mask
    assign slave_data_masked[gi] = head_slave_sel[gi] ? i_rsp_data[gi*DW +: DW] : '0;
    assign slave_err_masked[gi]  = head_slave_sel[gi] & i_rsp_err[gi];
  end

  always_comb begin
    merged_data = '0;
    for (int i = 0; i < NS; i++) begin
      merged_data = merged_data | slave_data_masked[i];
    end
  end

  assign merged_err = |slave_err_masked;

  always_comb begin
    wr_ptr_next    = wr_ptr_reg;
    rd_ptr_next    = rd_ptr_reg;
    count_next     = count_reg;
    rsp_valid_next = pop;
    rsp_err_next   = rsp_err_reg;
    rsp_data_next  = rsp_data_reg;
    fault_next     = fault_reg;

    if (i_flush) begin
      wr_ptr_next = '0;
      rd_ptr_next = '0;
      count_next  = '0;
    end else begin
      if (push) begin
        wr_ptr_next = wr_ptr_reg + 1'b1;
      end
      if (pop) begin
        rd_ptr_next = rd_ptr_reg + 1'b1;
      end
      case ({push, pop})
        2'b10:   count_next = count_reg + 1'b1;
        2'b01:   count_next = count_reg - 1'b1;
        default: count_next = count_reg;
      endcase
      if (stray_rsp || (i_req_valid && !decode_ok)) begin
        fault_next = 1'b1;
      end
    end

    if (pop) begin
      if (nsl_pop) begin
        rsp_data_next = '0;
        rsp_err_next  = 1'b1;
      end else begin
        rsp_data_next = merged_data;
        rsp_err_next  = merged_err;
      end
    end else if (OPT_LOWPOWER) begin
      rsp_data_next = '0;
      rsp_err_next  = 1'b0;
    end
  end

  always_ff @(posedge i_clk) begin
    if (!i_resetn) begin
      wr_ptr_reg    <= '0;
      rd_ptr_reg    <= '0;
      count_reg     <= '0;
      rsp_valid_reg <= 1'b0;
      rsp_err_reg   <= 1'b0;
      rsp_data_reg  <= '0;
      fault_reg     <= 1'b0;
    end else begin
      wr_ptr_reg    <= wr_ptr_next;
      rd_ptr_reg    <= rd_ptr_next;
      count_reg     <= count_next;
      rsp_valid_reg <= rsp_valid_next;
      rsp_err_reg   <= rsp_err_next;
      rsp_data_reg  <= rsp_data_next;
      fault_reg     <= fault_next;
    end
  end

  // Storage needs no reset: entries are only observed while counted valid.
  always_ff @(posedge i_clk) begin
    if (i_resetn && push) begin
      fifo_mem[wr_ptr_reg] <= i_req_decode;
    end
  end

  assign o_rsp_valid   = rsp_valid_reg;
  assign o_rsp_err     = rsp_err_reg;
  assign o_rsp_data    = rsp_data_reg;
  assign o_outstanding = count_reg;
  assign o_fault       = fault_reg;

endmodule

// File: tb/tb_la_zip_respmerge.sv
// -----------------------------------------------------------------------------
// tb_la_zip_respmerge
//   Directed bench for la_zip_respmerge (NS=8, DW=32, LGDEPTH=3). Each vector
//   is one clock: inputs are applied, the clock ticks, and all outputs are
//   compared 1 time unit after the edge. Slave k drives data (base ^ k).
// -----------------------------------------------------------------------------
module tb_la_zip_respmerge;

  localparam int NS      = 8;
  localparam int DW      = 32;
  localparam int LGDEPTH = 3;

  logic              clk = 1'b0;
  logic              resetn;
  logic              flush;
  logic              req_valid;
  logic [NS:0]       req_decode;
  logic              req_stall;
  logic [NS-1:0]     rsp_valid_in;
  logic [NS-1:0]     rsp_err_in;
  logic [NS*DW-1:0]  rsp_data_in;
  logic              rsp_valid;
  logic              rsp_err;
  logic [DW-1:0]     rsp_data;
  logic [LGDEPTH:0]  outstanding;
  logic              fault;

  int tests_run = 0;
  int tests_failed = 0;

  always #5 clk = ~clk;

  la_zip_respmerge #(
    .NS(NS), .DW(DW), .LGDEPTH(LGDEPTH), .OPT_LOWPOWER(1'b0)
  ) dut (
    .i_clk         (clk),
    .i_resetn      (resetn),
    .i_flush       (flush),
    .i_req_valid   (req_valid),
    .i_req_decode  (req_decode),
    .o_req_stall   (req_stall),
    .i_rsp_valid   (rsp_valid_in),
    .i_rsp_err     (rsp_err_in),
    .i_rsp_data    (rsp_data_in),
    .o_rsp_valid   (rsp_valid),
    .o_rsp_err     (rsp_err),
    .o_rsp_data    (rsp_data),
    .o_outstanding (outstanding),
    .o_fault       (fault)
  );

  typedef struct {
    logic [8*12-1:0] name;
    logic            resetn;
    logic            flush;
    logic            req;
    logic [8:0]      dec;
    logic [7:0]      rv;
    logic [7:0]      re;
    logic [31:0]     base;
    logic            e_valid;
    logic            e_err;
    logic [31:0]     e_data;
    logic [3:0]      e_out;
    logic            e_stall;
    logic            e_fault;
  } vec_t;

  vec_t vecs[$];

  function automatic vec_t mk(input logic [8*12-1:0] name, input logic rn, input logic fl,
                              input logic rq, input logic [8:0] dec, input logic [7:0] rv,
                              input logic [7:0] re, input logic [31:0] base,
                              input logic ev, input logic ee, input logic [31:0] ed,
                              input logic [3:0] eo, input logic es, input logic ef);
    vec_t v;
    v.name = name; v.resetn = rn; v.flush = fl; v.req = rq; v.dec = dec;
    v.rv = rv; v.re = re; v.base = base;
    v.e_valid = ev; v.e_err = ee; v.e_data = ed; v.e_out = eo;
    v.e_stall = es; v.e_fault = ef;
    return v;
  endfunction

  task automatic chk(input logic [8*12-1:0] name, input logic [8*8-1:0] field,
                     input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %0s.%0s got=%h expected=%h", name, field, got, exp);
    end
  endtask

  task automatic run(input vec_t v);
    resetn       = v.resetn;
    flush        = v.flush;
    req_valid    = v.req;
    req_decode   = v.dec;
    rsp_valid_in = v.rv;
    rsp_err_in   = v.re;
    for (int k = 0; k < NS; k++) begin
      rsp_data_in[k*DW +: DW] = v.base ^ 32'(k);
    end
    @(posedge clk);
    #1;
    chk(v.name, "valid", 32'(rsp_valid),   32'(v.e_valid));
    chk(v.name, "err",   32'(rsp_err),     32'(v.e_err));
    chk(v.name, "data",  rsp_data,         v.e_data);
    chk(v.name, "outst", 32'(outstanding), 32'(v.e_out));
    chk(v.name, "stall", 32'(req_stall),   32'(v.e_stall));
    chk(v.name, "fault", 32'(fault),       32'(v.e_fault));
    $display("[TB] %0s: req=%b dec=%h rv=%h -> vld=%b err=%b data=%h out=%0d stall=%b fault=%b",
             v.name, v.req, v.dec, v.rv, rsp_valid, rsp_err, rsp_data, outstanding,
             req_stall, fault);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [31:0] b;
    logic [31:0] hold;

    resetn = 1'b0; flush = 1'b0; req_valid = 1'b0; req_decode = '0;
    rsp_valid_in = '0; rsp_err_in = '0; rsp_data_in = '0;

    // name resetn flush req dec rv re base | vld err data out stall fault
    vecs.push_back(mk("rst0",     0,0,1,9'h004,8'hFF,8'hFF,32'hFFFF_FFFF, 0,0,32'h0,4'd0,0,0));
    vecs.push_back(mk("rst1",     0,0,1,9'h004,8'hFF,8'hFF,32'hFFFF_FFFF, 0,0,32'h0,4'd0,0,0));
    vecs.push_back(mk("idle",     1,0,0,9'h000,8'h00,8'h00,32'h0,         0,0,32'h0,4'd0,0,0));
    // In-order: slave2, slave0, no-slave
    vecs.push_back(mk("io_push2", 1,0,1,9'h004,8'h00,8'h00,32'h0,         0,0,32'h0,4'd1,0,0));
    vecs.push_back(mk("io_push0", 1,0,1,9'h001,8'h00,8'h00,32'h0,         0,0,32'h0,4'd2,0,0));
    vecs.push_back(mk("io_rsp2",  1,0,1,9'h100,8'h04,8'hFB,32'hA5A5_0002, 1,0,32'hA5A5_0000,4'd2,0,0));
    vecs.push_back(mk("io_wait",  1,0,0,9'h000,8'h00,8'h00,32'h0,         0,0,32'hA5A5_0000,4'd2,0,0));
    vecs.push_back(mk("io_rsp0",  1,0,0,9'h000,8'h01,8'h01,32'h1234_5670, 1,1,32'h1234_5670,4'd1,0,0));
    vecs.push_back(mk("io_nslave",1,0,0,9'h000,8'h00,8'h00,32'h0,         1,1,32'h0,4'd0,0,0));
    vecs.push_back(mk("io_idle",  1,0,0,9'h000,8'h00,8'h00,32'h0,         0,1,32'h0,4'd0,0,0));
    // Unexpected responder, then the proper one
    vecs.push_back(mk("ux_push1", 1,0,1,9'h002,8'h00,8'h00,32'h0,         0,1,32'h0,4'd1,0,0));
    vecs.push_back(mk("ux_rsp5",  1,0,0,9'h000,8'h20,8'h00,32'h0,         0,1,32'h0,4'd1,0,1));
    vecs.push_back(mk("ux_rsp1",  1,0,0,9'h000,8'h02,8'h00,32'hCAFE_0000, 1,0,32'hCAFE_0001,4'd0,0,1));
    vecs.push_back(mk("ux_rst",   0,0,0,9'h000,8'h00,8'h00,32'h0,         0,0,32'h0,4'd0,0,0));
    // Illegal decodes
    vecs.push_back(mk("bad_dec3", 1,0,1,9'h003,8'h00,8'h00,32'h0,         0,0,32'h0,4'd0,0,1));
    vecs.push_back(mk("bad_rst",  0,0,0,9'h000,8'h00,8'h00,32'h0,         0,0,32'h0,4'd0,0,0));
    vecs.push_back(mk("bad_dec0", 1,0,1,9'h000,8'h00,8'h00,32'h0,         0,0,32'h0,4'd0,0,1));
    vecs.push_back(mk("rst_end",  0,0,0,9'h000,8'h00,8'h00,32'h0,         0,0,32'h0,4'd0,0,0));

    foreach (vecs[i]) run(vecs[i]);

    // Full: fill to DEPTH, hold the 9th, free one slot, accept next cycle.
    for (int k = 1; k <= 8; k++) begin
      run(mk("full_push", 1,0,1,9'h002,8'h00,8'h00,32'h0, 0,0,32'h0,4'(k),(k == 8),0));
    end
    run(mk("full_hold", 1,0,1,9'h002,8'h00,8'h00,32'h0,       0,0,32'h0,4'd8,1,0));
    run(mk("full_pop",  1,0,1,9'h002,8'h02,8'h00,32'h0000_0100,1,0,32'h0000_0101,4'd7,0,0));
    run(mk("full_push9",1,0,1,9'h002,8'h00,8'h00,32'h0,       0,0,32'h0000_0101,4'd8,1,0));
    for (int k = 0; k < 8; k++) begin
      b = 32'h0000_0200 + 32'(k);
      run(mk("full_drain",1,0,0,9'h000,8'h02,8'h00,b, 1,0,b ^ 32'h1,4'(7 - k),0,0));
    end
    hold = 32'h0000_0207 ^ 32'h1;

    // Wrap: back-to-back push+pop to slave 3 across several pointer wraps.
    run(mk("wrap_first", 1,0,1,9'h008,8'h00,8'h00,32'h0, 0,0,hold,4'd1,0,0));
    for (int k = 0; k < 19; k++) begin
      b = 32'h3000_0000 + 32'(k);
      run(mk("wrap_pair", 1,0,1,9'h008,8'h08,8'h00,b, 1,0,b ^ 32'h3,4'd1,0,0));
    end
    b = 32'h3000_0000 + 32'd19;
    run(mk("wrap_last", 1,0,0,9'h000,8'h08,8'h00,b, 1,0,b ^ 32'h3,4'd0,0,0));
    hold = b ^ 32'h3;

    // Flush beats a simultaneous push and head response; late response faults.
    run(mk("fl_push", 1,0,1,9'h010,8'h00,8'h00,32'h0, 0,0,hold,4'd1,0,0));
    run(mk("fl_push", 1,0,1,9'h010,8'h00,8'h00,32'h0, 0,0,hold,4'd2,0,0));
    run(mk("fl_push", 1,0,1,9'h010,8'h00,8'h00,32'h0, 0,0,hold,4'd3,0,0));
    run(mk("fl_flush",1,1,1,9'h010,8'h10,8'h10,32'h0, 0,0,hold,4'd0,0,0));
    run(mk("fl_late", 1,0,0,9'h000,8'h10,8'h00,32'h0, 0,0,hold,4'd0,0,1));
    run(mk("fl_idle", 1,0,0,9'h000,8'h00,8'h00,32'h0, 0,0,hold,4'd0,0,1));

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
